// File: rtl/mpc_ref_cnt_if.sv
// mpc_ref_cnt_if: read/increment/decrement bus between the hit-test pipeline and the reference-counter array.
interface mpc_ref_cnt_if #(
    parameter int SET_NUM   = 64,
    parameter int WAY_NUM   = 4,
    parameter int CNT_WIDTH = 3,
    parameter int SET_W     = $clog2(SET_NUM),
    parameter int WAY_W     = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
);
    logic [SET_W-1:0]               rd_set;
    logic [WAY_NUM*CNT_WIDTH-1:0]   rd_rsp;
    logic                           acc_valid;
    logic [SET_W-1:0]               acc_set;
    logic [WAY_W-1:0]               acc_way;
    logic                           rel_valid;
    logic [SET_W-1:0]               rel_set;
    logic [WAY_W-1:0]               rel_way;
    logic                           init_done;

    modport master (
        output rd_set, acc_valid, acc_set, acc_way, rel_valid, rel_set, rel_way,
        input  rd_rsp, init_done
    );

    modport slave (
        input  rd_set, acc_valid, acc_set, acc_way, rel_valid, rel_set, rel_way,
        output rd_rsp, init_done
    );
endinterface

// File: rtl/mpc_ref_cnt.sv
// mpc_ref_cnt: per-(set,way) saturating reference counters with forwarded 1-cycle set read and post-reset clear sweep.
// Optional sticky error flags (err_ovf, err_udf, err_init_acc) are built when MPC_REF_CNT_ERR_CHK_EN is defined.
module mpc_ref_cnt #(
    parameter int SET_NUM   = 64,
    parameter int WAY_NUM   = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
`ifdef MPC_REF_CNT_ERR_CHK_EN
    output logic              err_ovf,
    output logic              err_udf,
    output logic              err_init_acc,
`endif
    mpc_ref_cnt_if.slave      bus
);
    localparam int SET_W = $clog2(SET_NUM);
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(SET_NUM - 1);

    typedef enum logic {INIT, RUN} state_t;
    typedef logic [WAY_NUM-1:0][CNT_WIDTH-1:0] set_cnt_t;

    state_t                state_q, state_d;
    logic [SET_W-1:0]      init_ptr_q, init_ptr_d;
    logic                  init_done_q, init_done_d;
    set_cnt_t              rd_rsp_q, rd_rsp_d;
    set_cnt_t              cnt_q [SET_NUM];
    set_cnt_t              cnt_d [SET_NUM];
    logic [CNT_WIDTH-1:0]  acc_cur, rel_cur;
    logic                  run, same;

    always_comb begin
        run     = state_q == RUN;
        acc_cur = cnt_q[bus.acc_set][bus.acc_way];
        rel_cur = cnt_q[bus.rel_set][bus.rel_way];
        // an increment and decrement of the same line cancel, even at the saturation limits
        same    = bus.acc_valid && bus.rel_valid && bus.acc_set == bus.rel_set && bus.acc_way == bus.rel_way;
        cnt_d   = cnt_q;
        if (!run)
            cnt_d[init_ptr_q] = '0;
        else if (!same) begin
            if (bus.acc_valid)
                cnt_d[bus.acc_set][bus.acc_way] = (acc_cur == CMAX) ? acc_cur : acc_cur + CNT_WIDTH'(1);
            if (bus.rel_valid)
                cnt_d[bus.rel_set][bus.rel_way] = (rel_cur == '0) ? rel_cur : rel_cur - CNT_WIDTH'(1);
        end
        state_d     = (!run && init_ptr_q == LAST_SET) ? RUN : state_q;
        init_ptr_d  = run ? init_ptr_q : init_ptr_q + SET_W'(1);
        init_done_d = state_d == RUN;
        rd_rsp_d    = run ? cnt_d[bus.rd_set] : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_ptr_q  <= '0;
            init_done_q <= 1'b0;
            rd_rsp_q    <= '1;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            init_done_q <= init_done_d;
            rd_rsp_q    <= rd_rsp_d;
        end
    end

    // storage is never reset; the sweep clears it and reset only drops the in-flight update
    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= cnt_d;
    end

    assign bus.rd_rsp    = rd_rsp_q;
    assign bus.init_done = init_done_q;

`ifdef MPC_REF_CNT_ERR_CHK_EN
    logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d, err_init_q, err_init_d;

    always_comb begin
        err_ovf_d  = err_ovf_q  || (run && bus.acc_valid && !same && acc_cur == CMAX);
        err_udf_d  = err_udf_q  || (run && bus.rel_valid && !same && rel_cur == '0);
        err_init_d = err_init_q || (!run && (bus.acc_valid || bus.rel_valid));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q  <= 1'b0;
            err_udf_q  <= 1'b0;
            err_init_q <= 1'b0;
        end else begin
            err_ovf_q  <= err_ovf_d;
            err_udf_q  <= err_udf_d;
            err_init_q <= err_init_d;
        end
    end

    assign err_ovf      = err_ovf_q;
    assign err_udf      = err_udf_q;
    assign err_init_acc = err_init_q;
`endif
endmodule
